// File: rtl/sdram_access_arbiter.sv
// SDRAM port arbiter: shares one sequencer port between the CPU and DMA
// requesters and owns the refresh schedule (debt counting, hidden refreshes
// in idle gaps, forced refresh at the debt limit).
module sdram_access_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 512,
  parameter int unsigned MAX_DEBT         = 4,
  parameter int unsigned CNT_W            = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INIT_DONE,
  input  logic        CPU_REQ,
  input  logic        CPU_RW,
  input  logic [22:0] CPU_A,
  input  logic [1:0]  CPU_BE,
  input  logic        DMA_REQ,
  input  logic        DMA_RW,
  input  logic [22:0] DMA_A,
  input  logic [1:0]  DMA_BE,
  input  logic        SD_DONE,
  output logic        SD_REQ,
  output logic        SD_REFRESH,
  output logic        SD_RW,
  output logic [22:0] SD_A,
  output logic [1:0]  SD_BE,
  output logic        CPU_GNT,
  output logic        DMA_GNT,
  output logic        CPU_DONE,
  output logic        DMA_DONE,
  output logic [2:0]  REF_DEBT,
  output logic        REF_OVERRUN
);

  typedef enum logic [2:0] {
    StIdle,
    StCpuAcc,
    StDmaAcc,
    StRef,
    StHoldoff
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]       DebtMax = 3'(MAX_DEBT);

  state_e           state;
  logic [CNT_W-1:0] interval_cnt;
  logic [2:0]       debt;
  logic             last_cpu;   // 1: CPU owned the port last, 0: DMA
  logic             blk_cpu;    // port just completed, kept out of the next IDLE
  logic             blk_dma;
  logic             tick;
  logic             ref_done;
  logic             cpu_elig;
  logic             dma_elig;

  assign tick     = INIT_DONE && (interval_cnt == CntLast);
  assign ref_done = (state == StRef) && SD_DONE;
  assign cpu_elig = CPU_REQ && !blk_cpu;
  assign dma_elig = DMA_REQ && !blk_dma;
  assign REF_DEBT = debt;

  // Refresh interval counter; frozen at zero until the sequencer is initialised.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      interval_cnt <= '0;
    end else if (!INIT_DONE || (interval_cnt == CntLast)) begin
      interval_cnt <= '0;
    end else begin
      interval_cnt <= interval_cnt + CNT_W'(1);
    end
  end

  // Refresh debt: ticks add, completed refreshes subtract, both together cancel.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      debt        <= 3'd0;
      REF_OVERRUN <= 1'b0;
    end else begin
      if (tick && (debt == DebtMax)) begin
        REF_OVERRUN <= 1'b1;
      end
      if (tick && !ref_done && (debt != DebtMax)) begin
        debt <= debt + 3'd1;
      end else if (ref_done && !tick && (debt != 3'd0)) begin
        debt <= debt - 3'd1;
      end
    end
  end

  // Arbitration FSM with all sequencer-facing and requester-facing outputs registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= StIdle;
      last_cpu   <= 1'b0;
      blk_cpu    <= 1'b0;
      blk_dma    <= 1'b0;
      SD_REQ     <= 1'b0;
      SD_REFRESH <= 1'b0;
      SD_RW      <= 1'b0;
      SD_A       <= '0;
      SD_BE      <= '0;
      CPU_GNT    <= 1'b0;
      DMA_GNT    <= 1'b0;
      CPU_DONE   <= 1'b0;
      DMA_DONE   <= 1'b0;
    end else begin
      CPU_DONE <= 1'b0;
      DMA_DONE <= 1'b0;
      unique case (state)
        StIdle: begin
          blk_cpu <= 1'b0;
          blk_dma <= 1'b0;
          if (!INIT_DONE) begin
            state <= StIdle;
          end else if ((debt == DebtMax) ||
                       (!cpu_elig && !dma_elig && (debt != 3'd0))) begin
            state      <= StRef;
            SD_REFRESH <= 1'b1;
            SD_RW      <= 1'b0;
            SD_A       <= '0;
            SD_BE      <= '0;
          end else if (cpu_elig && (!dma_elig || !last_cpu)) begin
            state    <= StCpuAcc;
            SD_REQ   <= 1'b1;
            CPU_GNT  <= 1'b1;
            SD_RW    <= CPU_RW;
            SD_A     <= CPU_A;
            SD_BE    <= CPU_BE;
            last_cpu <= 1'b1;
          end else if (dma_elig) begin
            state    <= StDmaAcc;
            SD_REQ   <= 1'b1;
            DMA_GNT  <= 1'b1;
            SD_RW    <= DMA_RW;
            SD_A     <= DMA_A;
            SD_BE    <= DMA_BE;
            last_cpu <= 1'b0;
          end
        end
        StCpuAcc: begin
          if (SD_DONE) begin
            state    <= StHoldoff;
            SD_REQ   <= 1'b0;
            CPU_GNT  <= 1'b0;
            CPU_DONE <= 1'b1;
            blk_cpu  <= 1'b1;
          end
        end
        StDmaAcc: begin
          if (SD_DONE) begin
            state    <= StHoldoff;
            SD_REQ   <= 1'b0;
            DMA_GNT  <= 1'b0;
            DMA_DONE <= 1'b1;
            blk_dma  <= 1'b1;
          end
        end
        StRef: begin
          if (SD_DONE) begin
            state      <= StHoldoff;
            SD_REFRESH <= 1'b0;
          end
        end
        StHoldoff: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter (16-cycle refresh interval, debt limit 4).
module tb_sdram_access_arbiter;

  logic        CLK, RST, INIT_DONE;
  logic        CPU_REQ, CPU_RW, DMA_REQ, DMA_RW, SD_DONE;
  logic [22:0] CPU_A, DMA_A;
  logic [1:0]  CPU_BE, DMA_BE;
  logic        SD_REQ, SD_REFRESH, SD_RW, CPU_GNT, DMA_GNT, CPU_DONE, DMA_DONE, REF_OVERRUN;
  logic [22:0] SD_A;
  logic [1:0]  SD_BE;
  logic [2:0]  REF_DEBT;

  sdram_access_arbiter #(
    .REFRESH_INTERVAL(16),
    .MAX_DEBT        (4),
    .CNT_W           (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INIT_DONE  (INIT_DONE),
    .CPU_REQ    (CPU_REQ),
    .CPU_RW     (CPU_RW),
    .CPU_A      (CPU_A),
    .CPU_BE     (CPU_BE),
    .DMA_REQ    (DMA_REQ),
    .DMA_RW     (DMA_RW),
    .DMA_A      (DMA_A),
    .DMA_BE     (DMA_BE),
    .SD_DONE    (SD_DONE),
    .SD_REQ     (SD_REQ),
    .SD_REFRESH (SD_REFRESH),
    .SD_RW      (SD_RW),
    .SD_A       (SD_A),
    .SD_BE      (SD_BE),
    .CPU_GNT    (CPU_GNT),
    .DMA_GNT    (DMA_GNT),
    .CPU_DONE   (CPU_DONE),
    .DMA_DONE   (DMA_DONE),
    .REF_DEBT   (REF_DEBT),
    .REF_OVERRUN(REF_OVERRUN)
  );

  typedef struct {
    bit          cpu;   // requester issuing the access
    bit          rw;
    logic [22:0] a;
    logic [1:0]  be;
    int          lat;   // cycles from grant to SD_DONE
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   viol    = 0;
  int   t;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Exclusivity of requests and grants, sampled away from the active edge.
  always @(negedge CLK) begin
    if ((SD_REQ && SD_REFRESH) || (CPU_GNT && DMA_GNT)) viol++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] outs();
    return {SD_REQ, SD_REFRESH, SD_RW, SD_A, SD_BE, CPU_GNT, DMA_GNT, CPU_DONE, DMA_DONE,
            REF_DEBT, REF_OVERRUN};
  endfunction

  task automatic do_reset();
    RST = 1'b0; INIT_DONE = 1'b0; SD_DONE = 1'b0;
    CPU_REQ = 1'b0; CPU_RW = 1'b0; CPU_A = '0; CPU_BE = '0;
    DMA_REQ = 1'b0; DMA_RW = 1'b0; DMA_A = '0; DMA_BE = '0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 64'(outs()), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic adv_to(input int target);
    while (t < target) begin
      @(negedge CLK);
      t++;
    end
  endtask

  // Waits for a grant while acting as the sequencer for any refresh in between.
  task automatic wait_grant(output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(negedge CLK);
      lat++;
      if (CPU_GNT || DMA_GNT) begin
        got     = 1'b1;
        SD_DONE = 1'b0;
      end else begin
        SD_DONE = SD_REFRESH;
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic xfer(input vec_t v, output int lat);
    vec_t e;
    bit   got;
    exp_q.push_back(v);
    if (v.cpu) begin
      CPU_RW = v.rw; CPU_A = v.a; CPU_BE = v.be; CPU_REQ = 1'b1;
    end else begin
      DMA_RW = v.rw; DMA_A = v.a; DMA_BE = v.be; DMA_REQ = 1'b1;
    end
    wait_grant(got, lat);
    e = exp_q.pop_front();
    if (!got) begin
      CPU_REQ = 1'b0;
      DMA_REQ = 1'b0;
      return;
    end
    chk("gnt_owner", 64'({CPU_GNT, DMA_GNT, SD_REQ, SD_REFRESH}),
        64'({e.cpu, !e.cpu, 1'b1, 1'b0}));
    chk("latched", 64'({SD_RW, SD_BE, SD_A}), 64'({e.rw, e.be, e.a}));
    // Requester inputs wander mid-access; the latched copy must not follow.
    if (e.cpu) begin
      CPU_A = ~e.a; CPU_RW = ~e.rw; CPU_BE = ~e.be;
    end else begin
      DMA_A = ~e.a; DMA_RW = ~e.rw; DMA_BE = ~e.be;
    end
    repeat (e.lat - 1) @(negedge CLK);
    chk("latched_stable", 64'({SD_RW, SD_BE, SD_A, SD_REQ}), 64'({e.rw, e.be, e.a, 1'b1}));
    SD_DONE = 1'b1;
    @(negedge CLK);
    SD_DONE = 1'b0;
    chk("done_pulse", 64'({CPU_DONE, DMA_DONE, CPU_GNT, DMA_GNT, SD_REQ}),
        64'({e.cpu, !e.cpu, 3'b000}));
    @(negedge CLK);
    SD_DONE = SD_REFRESH;
    chk("done_width", 64'({CPU_DONE, DMA_DONE}), 64'd0);
    CPU_REQ = 1'b0;
    DMA_REQ = 1'b0;
    @(negedge CLK);
    SD_DONE = SD_REFRESH;
    chk("no_regrant", 64'({CPU_GNT, DMA_GNT}), 64'd0);
  endtask

  initial begin
    bit got;
    bit owner, prev_owner;
    int lat, ngrant, cd, act, drained;

    vecs[0] = '{1'b1, 1'b1, 23'h123456, 2'b11, 3};
    vecs[1] = '{1'b0, 1'b0, 23'h7FFFFF, 2'b01, 1};
    vecs[2] = '{1'b1, 1'b0, 23'h000000, 2'b10, 2};
    vecs[3] = '{1'b0, 1'b1, 23'h2AAAAA, 2'b11, 4};
    vecs[4] = '{1'b1, 1'b1, 23'h555555, 2'b00, 1};
    vecs[5] = '{1'b0, 1'b0, 23'h000001, 2'b10, 5};

    // Hidden refresh in idle gaps: tick at cycle 16+16k, refresh one cycle later.
    do_reset();
    INIT_DONE = 1'b1;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      adv_to(16 + 16 * k);
      chk("r1_debt_up", 64'({REF_DEBT, SD_REFRESH}), 64'({3'd1, 1'b0}));
      adv_to(17 + 16 * k);
      chk("r1_ref", 64'({SD_REFRESH, SD_REQ, SD_A, SD_BE, REF_DEBT}), 64'({2'b10, 25'd0, 3'd1}));
      SD_DONE = 1'b1;
      adv_to(18 + 16 * k);
      SD_DONE = 1'b0;
      chk("r1_drained", 64'({SD_REFRESH, REF_DEBT}), 64'd0);
    end

    // Refresh withheld: debt saturates, overrun sticks, debt limit beats a CPU request.
    do_reset();
    INIT_DONE = 1'b1;
    t = 0;
    CPU_RW = 1'b0; CPU_A = 23'h0ABCDE; CPU_BE = 2'b01;
    adv_to(79);
    chk("r2_sat", 64'({REF_DEBT, REF_OVERRUN, SD_REFRESH}), 64'({3'd4, 1'b0, 1'b1}));
    adv_to(80);
    chk("r2_overrun", 64'({REF_DEBT, REF_OVERRUN}), 64'({3'd4, 1'b1}));
    adv_to(95);
    SD_DONE = 1'b1;
    CPU_REQ = 1'b1;
    adv_to(96);
    SD_DONE = 1'b0;
    chk("r2_tick_and_dec", 64'({SD_REFRESH, REF_DEBT}), 64'({1'b0, 3'd4}));
    adv_to(98);
    chk("r2_ref_first", 64'({SD_REFRESH, CPU_GNT, SD_REQ}), 64'({1'b1, 1'b0, 1'b0}));
    SD_DONE = 1'b1;
    adv_to(99);
    SD_DONE = 1'b0;
    chk("r2_debt_dec", 64'(REF_DEBT), 64'd3);
    adv_to(101);
    chk("r2_cpu_after_ref", 64'({CPU_GNT, SD_REQ, SD_A}), 64'({2'b11, 23'h0ABCDE}));
    SD_DONE = 1'b1;
    adv_to(102);
    SD_DONE = 1'b0;
    chk("r2_cpu_done", 64'(CPU_DONE), 64'd1);
    adv_to(103);
    CPU_REQ = 1'b0;
    drained = 0;
    for (int i = 0; i < 120 && drained == 0; i++) begin
      @(negedge CLK);
      if (SD_REFRESH) chk("r2_ref_fields", 64'({SD_A, SD_BE}), 64'd0);
      SD_DONE = SD_REFRESH;
      if (!SD_REFRESH && REF_DEBT == 3'd0) drained = 1;
    end
    chk("r2_drain_done", 64'(drained), 64'd1);
    chk("r2_overrun_sticky", 64'({REF_DEBT, REF_OVERRUN}), 64'({3'd0, 1'b1}));

    // Table-driven single-requester accesses through the scoreboard.
    do_reset();
    INIT_DONE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i], lat);
      if (i == 0) chk("first_grant_latency", 64'(lat), 64'd1);
    end

    // Both requesters held: grants alternate, CPU wins the first tie after reset.
    do_reset();
    INIT_DONE = 1'b1;
    CPU_RW = 1'b1; CPU_A = 23'h111111; CPU_BE = 2'b11;
    DMA_RW = 1'b0; DMA_A = 23'h222222; DMA_BE = 2'b10;
    CPU_REQ = 1'b1;
    DMA_REQ = 1'b1;
    prev_owner = 1'b0;
    ngrant = 0;
    cd = 0;
    for (int i = 0; i < 600 && ngrant < 6; i++) begin
      @(negedge CLK);
      SD_DONE = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) SD_DONE = 1'b1;
      end else if (CPU_GNT || DMA_GNT) begin
        owner = CPU_GNT;
        if (ngrant == 0) chk("alt_first_cpu", 64'(owner), 64'd1);
        else chk("alt_turn", 64'(owner), 64'(!prev_owner));
        chk("alt_addr", 64'(SD_A), owner ? 64'h111111 : 64'h222222);
        prev_owner = owner;
        ngrant++;
        cd = 2;
      end else begin
        SD_DONE = SD_REFRESH;
      end
    end
    chk("alt_grants", 64'(ngrant), 64'd6);
    while (cd > 0) begin
      @(negedge CLK);
      cd--;
    end
    SD_DONE = 1'b1;
    CPU_REQ = 1'b0;
    DMA_REQ = 1'b0;
    @(negedge CLK);
    SD_DONE = 1'b0;

    // Stale CPU_REQ held through completion is not re-granted straight away.
    CPU_RW = 1'b0; CPU_A = 23'h3C3C3C; CPU_BE = 2'b11;
    CPU_REQ = 1'b1;
    wait_grant(got, lat);
    chk("blk_owner", 64'(CPU_GNT), 64'd1);
    SD_DONE = 1'b1;
    @(negedge CLK);
    SD_DONE = 1'b0;
    chk("blk_done", 64'(CPU_DONE), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("blk_hold", 64'(CPU_GNT), 64'd0);
      SD_DONE = SD_REFRESH;
    end
    wait_grant(got, lat);
    chk("blk_regrant", 64'(CPU_GNT), 64'd1);

    // INIT_DONE drops and CPU_REQ drops mid-access: the access still completes.
    INIT_DONE = 1'b0;
    CPU_REQ = 1'b0;
    DMA_RW = 1'b1; DMA_A = 23'h0F0F0F; DMA_BE = 2'b01;
    DMA_REQ = 1'b1;
    repeat (2) @(negedge CLK);
    chk("init_low_hold", 64'({CPU_GNT, SD_REQ}), 64'({2'b11}));
    SD_DONE = 1'b1;
    @(negedge CLK);
    SD_DONE = 1'b0;
    chk("init_low_done", 64'({CPU_DONE, CPU_GNT}), 64'({2'b10}));
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      SD_DONE = (i == 5);  // stray pulse while idle must be ignored
      if (SD_REQ || SD_REFRESH || CPU_GNT || DMA_GNT || CPU_DONE || DMA_DONE) act++;
    end
    SD_DONE = 1'b0;
    chk("init_low_idle", 64'(act), 64'd0);
    INIT_DONE = 1'b1;
    wait_grant(got, lat);
    chk("init_back_dma", 64'({DMA_GNT, SD_A, SD_RW}), 64'({1'b1, 23'h0F0F0F, 1'b1}));

    // Asynchronous reset in the middle of the DMA access.
    #2 RST = 1'b0;
    #1 chk("async_reset", 64'(outs()), 64'd0);
    @(negedge CLK);
    DMA_REQ = 1'b0;
    RST = 1'b1;
    @(negedge CLK);

    chk("exclusive", 64'(viol), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Sits between the bus-side requesters and the SDRAM command sequencer.
- Shares the single SDRAM port between the CPU bus port and a DMA/blitter port.
- Owns the refresh schedule: counts refresh debt, hides refreshes in idle gaps, and forces a refresh when the debt limit is reached.
- Presents one registered request at a time (access or refresh) to the sequencer and routes completion back to the owner.

Parameters:
- REFRESH_INTERVAL, 512: CLK cycles per refresh tick.
- MAX_DEBT, 4: refresh ticks owed before a refresh pre-empts pending accesses. Range 1..7.
- CNT_W, 10: width of the interval counter. Must satisfy 2^CNT_W >= REFRESH_INTERVAL.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- INIT_DONE  in  1  sequencer power-up init complete; no grants while low
- CPU_REQ  in  1  CPU access request, level, held until CPU_DONE
- CPU_RW  in  1  1=read, 0=write
- CPU_A  in  23  word address A[23:1]
- CPU_BE  in  2  byte enables {upper,lower}, active-high
- DMA_REQ  in  1  DMA access request, level, held until DMA_DONE
- DMA_RW  in  1  1=read, 0=write
- DMA_A  in  23  word address
- DMA_BE  in  2  byte enables
- SD_DONE  in  1  one-cycle pulse from sequencer: current operation finished
- SD_REQ  out  1  access request to sequencer
- SD_REFRESH  out  1  refresh request to sequencer
- SD_RW  out  1  latched direction
- SD_A  out  23  latched address
- SD_BE  out  2  latched byte enables
- CPU_GNT  out  1  CPU owns SDRAM port
- DMA_GNT  out  1  DMA owns SDRAM port
- CPU_DONE  out  1  one-cycle completion pulse to CPU
- DMA_DONE  out  1  one-cycle completion pulse to DMA
- REF_DEBT  out  3  current refresh debt
- REF_OVERRUN  out  1  sticky: a tick arrived while debt was already MAX_DEBT

Behaviour:
- Reset values (RST low, async): state=IDLE; all outputs 0; SD_A=0; interval counter=0; debt=0; last_owner=DMA, so the CPU wins the first tie.
- Interval counter runs only while INIT_DONE=1; otherwise it holds at 0.
  - Counter wraps at REFRESH_INTERVAL-1; the wrap cycle is the tick.
  - Tick increments debt, saturating at MAX_DEBT. A tick at saturation sets REF_OVERRUN, which clears only on reset.
  - Debt decrements on SD_DONE while in REF.
  - Tick and decrement in the same cycle leave debt unchanged.
- States: IDLE, CPU_ACC, DMA_ACC, REF, HOLDOFF. Every transition is registered: a grant appears the cycle after the request is sampled.
- IDLE, evaluated in priority order:
  - INIT_DONE=0: stay in IDLE.
  - debt==MAX_DEBT: go to REF.
  - Both CPU_REQ and DMA_REQ eligible: grant the port that is not last_owner (round-robin).
  - Exactly one eligible: grant that port.
  - No request and debt>0: go to REF.
  - Otherwise: stay in IDLE.
- On grant:
  - Latch the owner's RW/A/BE into SD_RW/SD_A/SD_BE.
  - Assert xxx_GNT and SD_REQ; update last_owner.
  - Latched fields stay stable until exit, even if the requester's inputs change.
- CPU_ACC / DMA_ACC:
  - Hold SD_REQ and GNT until SD_DONE.
  - On SD_DONE: drop SD_REQ and GNT next cycle, pulse the owner's DONE for exactly one cycle, go to HOLDOFF.
- REF:
  - Hold SD_REFRESH=1 with SD_A=0 and SD_BE=0 until SD_DONE.
  - On SD_DONE: drop SD_REFRESH, decrement debt, go to HOLDOFF.
- HOLDOFF:
  - Lasts one cycle, then returns to IDLE.
  - The port just completed is ineligible this cycle and the next, so its stale REQ cannot be re-granted before it deasserts.
- SD_REQ and SD_REFRESH are mutually exclusive and never both high. At most one GNT is high.
- SD_DONE outside CPU_ACC/DMA_ACC/REF is ignored.
- A requester dropping REQ mid-access does not abort it. The access completes and DONE still pulses.
- INIT_DONE falling mid-operation: the current operation completes normally; no new grant until INIT_DONE=1.
- Async reset mid-operation returns immediately to reset values. The sequencer must be reset alongside.

Test Plan:
- Reset, then INIT_DONE=1, CPU_REQ=1, CPU_A=0x123456, RW=1, BE=2'b11 -> next cycle CPU_GNT=1, SD_REQ=1, SD_A=0x123456. SD_DONE pulse -> CPU_DONE high for exactly 1 cycle, CPU_GNT/SD_REQ low the same cycle.
- CPU_REQ and DMA_REQ both held continuously, SD_DONE returned 3 cycles after each grant -> grants alternate CPU, DMA, CPU, DMA; no port gets two consecutive grants.
- REFRESH_INTERVAL=16, no requests -> SD_REFRESH asserts within 2 cycles after each tick; REF_DEBT returns to 0 after each SD_DONE.
- REFRESH_INTERVAL=16, MAX_DEBT=2, CPU_REQ held continuously -> after the second tick the next IDLE goes to REF ahead of the CPU, then the CPU is granted again.
- SD_DONE withheld for 5 ticks with MAX_DEBT=4 -> REF_DEBT saturates at 4 and REF_OVERRUN=1, remaining set after debt drains.
- Change CPU_A mid-access -> SD_A unchanged until DONE. Drop CPU_REQ one cycle after CPU_DONE -> no second CPU grant. Assert RST mid-access -> all outputs 0 immediately.
